// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory bus between the fetch (FE) and data (MEM) ports.
// Data wins ties; a starvation guard and a bus timeout keep both ports making progress.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fe_req,
    input  logic [31:0] fe_addr,
    output logic [31:0] fe_q,
    output logic        fe_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_q,
    output logic        mem_done,
    output logic        bus_start,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data,
    output logic        bus_we,
    input  logic [31:0] bus_q,
    input  logic        bus_done,
    output logic        bus_err
);
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state;
    logic        gnt_mem;
    logic [31:0] starve_cnt;
    logic [31:0] wait_cnt;
    logic        fe_starved;
    logic        mem_wins;
    logic        timed_out;
    logic [31:0] rsp_q;

    assign fe_starved = fe_req && (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT);
    assign mem_wins   = mem_req && !fe_starved;
    assign timed_out  = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);
    // Writes return 0; an aborted transaction returns all ones.
    assign rsp_q      = !bus_done ? 32'hFFFF_FFFF : (bus_we ? 32'h0 : bus_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            gnt_mem    <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            fe_q       <= '0;
            fe_done    <= 1'b0;
            mem_q      <= '0;
            mem_done   <= 1'b0;
            bus_start  <= 1'b0;
            bus_addr   <= '0;
            bus_data   <= '0;
            bus_we     <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            bus_start <= 1'b0;
            fe_done   <= 1'b0;
            mem_done  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (mem_wins) begin
                        state     <= StWait;
                        gnt_mem   <= 1'b1;
                        bus_start <= 1'b1;
                        bus_addr  <= mem_addr;
                        bus_we    <= mem_we;
                        bus_data  <= mem_we ? mem_data : 32'h0;
                        if (fe_req && starve_cnt != STARVE_LIMIT) begin
                            starve_cnt <= starve_cnt + 1;
                        end
                    end else if (fe_req) begin
                        state      <= StWait;
                        gnt_mem    <= 1'b0;
                        bus_start  <= 1'b1;
                        bus_addr   <= fe_addr;
                        bus_we     <= 1'b0;
                        bus_data   <= 32'h0;
                        starve_cnt <= '0;
                    end
                    if (!fe_req) begin
                        starve_cnt <= '0;
                    end
                end
                StWait: begin
                    if (bus_done || timed_out) begin
                        state <= StResp;
                        if (gnt_mem) begin
                            mem_q    <= rsp_q;
                            mem_done <= 1'b1;
                        end else begin
                            fe_q    <= rsp_q;
                            fe_done <= 1'b1;
                        end
                        if (!bus_done) begin
                            bus_err <= 1'b1;
                        end
                    end
                    if (!bus_done) begin
                        wait_cnt <= wait_cnt + 1;
                    end
                end
                StResp: begin
                    wait_cnt <= '0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
